wormhole_inject_arbiter: RTL

- Per-node injection controller in front of a mesh router's local input port.
- Shares that port among NUM_REQ local requesters using round-robin arbitration.
- Each granted request is a destination plus a 32-bit word. The block serialises it into a 7-flit wormhole packet: head, 5 body, tail.
- Honours router_out_full back-pressure and never interleaves flits of different packets.

---
 rtl/wh_noc_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/wormhole_inject_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/wh_noc_pkg.sv
// wh_noc_pkg: flit format constants, injector FSM states and flit encoders.
package wh_noc_pkg;
   localparam logic [1:0] FLIT_HEAD = 2'b00;
   localparam logic [1:0] FLIT_BODY = 2'b01;
   localparam logic [1:0] FLIT_TAIL = 2'b10;
   localparam int BODY_FLITS = 5;
   localparam int PKT_FLITS = 7;
   typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_BODY, ST_TAIL} state_t;
   function automatic logic [7:0] head_flit(input logic [2:0] x, input logic [2:0] y);
      return {x, y, FLIT_HEAD};
   endfunction
   // body k carries data[31-6k -: 6]; shifting keeps the slice at the top
   function automatic logic [7:0] body_flit(input logic [31:0] d, input logic [2:0] k);
      logic [31:0] s;
      s = d << (6 * k);
      return {s[31:26], FLIT_BODY};
   endfunction
   function automatic logic [7:0] tail_flit(input logic [31:0] d);
      return {d[1:0], 4'b0000, FLIT_TAIL};
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set req at or after ptr with wrap.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx
);
   logic [IDX_W-1:0] c;
   logic found;
   always_comb begin
      gnt = '0;
      idx = '0;
      found = 1'b0;
      c = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         c = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[c]) begin
            found = 1'b1;
            gnt[c] = 1'b1;
            idx = c;
         end
      end
   end
endmodule

// File: rtl/wormhole_inject_arbiter.sv
// wormhole_inject_arbiter: round-robin injector serialising requests into 7-flit wormhole packets.
// Optional WH_INJ_STATS_EN adds pkt_count and stall_count outputs.
module wormhole_inject_arbiter
   import wh_noc_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int LINK_WIDTHS = 8,
   parameter int COORD_W = 3,
   parameter int PAYLOAD_W = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*COORD_W-1:0]   req_dst_x,
   input  logic [NUM_REQ*COORD_W-1:0]   req_dst_y,
   input  logic [NUM_REQ*PAYLOAD_W-1:0] req_data,
   output logic [NUM_REQ-1:0]           ack,
   output logic                         busy,
   input  logic                         router_out_full,
   output logic [LINK_WIDTHS-1:0]       out_flit,
   output logic                         out_wr_en
`ifdef WH_INJ_STATS_EN
   ,
   output logic [15:0]                  pkt_count,
   output logic [15:0]                  stall_count
`endif
);
   localparam int IDX_W = $clog2(NUM_REQ);
   state_t state;
   logic [IDX_W-1:0] rr_ptr, grant, arb_idx;
   logic [NUM_REQ-1:0] owner, arb_gnt;
   logic [2:0] bidx;
   logic [COORD_W-1:0] sel_x, sel_y;
   logic [PAYLOAD_W-1:0] sel_d, data;
   logic tail_xfer;
   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req(req), .ptr(rr_ptr), .gnt(arb_gnt), .idx(arb_idx)
   );
   assign sel_x = req_dst_x[arb_idx*COORD_W +: COORD_W];
   assign sel_y = req_dst_y[arb_idx*COORD_W +: COORD_W];
   assign sel_d = req_data[arb_idx*PAYLOAD_W +: PAYLOAD_W];
   assign busy = state != ST_IDLE;
   assign out_wr_en = busy && !router_out_full;
   assign tail_xfer = out_wr_en && state == ST_TAIL;
   assign ack = tail_xfer ? owner : '0;
   // out_flit always holds the flit of the current state, so a stall simply holds registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         rr_ptr <= '0;
         grant <= '0;
         owner <= '0;
         bidx <= '0;
         data <= '0;
         out_flit <= '0;
      end else begin
         case (state)
            ST_IDLE: if (|req) begin
               grant <= arb_idx;
               owner <= arb_gnt;
               data <= sel_d;
               out_flit <= head_flit(sel_x, sel_y);
               state <= ST_HEAD;
            end
            ST_HEAD: if (out_wr_en) begin
               bidx <= '0;
               out_flit <= body_flit(data, 3'd0);
               state <= ST_BODY;
            end
            ST_BODY: if (out_wr_en) begin
               if (bidx == 3'(BODY_FLITS - 1)) begin
                  out_flit <= tail_flit(data);
                  state <= ST_TAIL;
               end else begin
                  bidx <= bidx + 3'd1;
                  out_flit <= body_flit(data, bidx + 3'd1);
               end
            end
            default: if (out_wr_en) begin
               rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
               bidx <= '0;
               out_flit <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end
`ifdef WH_INJ_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_count <= '0;
         stall_count <= '0;
      end else begin
         pkt_count <= pkt_count + 16'(tail_xfer);
         stall_count <= (busy && router_out_full && stall_count != 16'hFFFF) ? stall_count + 16'd1 : stall_count;
      end
   end
`endif
endmodule
